// File: rtl/stage_ex_if.sv
// Decode-to-execute-to-memory bundle for stage_ex: decode drives the *_i side,
// stage_ex returns stall_o and the registered *_o side toward stage_mem.
interface stage_ex_if #(
  parameter int WD_SIZE        = 32,
  parameter int INSTR_SIZE     = 32,
  parameter int INSTR_REG_BITS = 5
);
  logic                      valid_i;
  logic [INSTR_SIZE-1:0]     pc_i;
  logic [INSTR_REG_BITS-1:0] rd_i;
  logic [WD_SIZE-1:0]        rs1_data_i;
  logic [WD_SIZE-1:0]        rs2_data_i;
  logic [WD_SIZE-1:0]        imm_i;
  logic                      use_imm_i;
  logic [3:0]                alu_op_i;
  logic                      instr_op_i;
  logic                      instr_ld_i;
  logic                      instr_st_i;
  logic                      instr_jm_i;
  logic                      instr_br_i;
  logic                      flush_i;

  logic                      stall_o;
  logic                      valid_o;
  logic [INSTR_SIZE-1:0]     pc_o;
  logic [INSTR_REG_BITS-1:0] rd_o;
  logic [WD_SIZE-1:0]        alu_result_o;
  logic                      alu_zero_o;
  logic [WD_SIZE-1:0]        rs2_data_o;
  logic                      instr_op_o;
  logic                      instr_ld_o;
  logic                      instr_st_o;
  logic                      instr_jm_o;
  logic                      instr_br_o;

  modport master (
    output valid_i, pc_i, rd_i, rs1_data_i, rs2_data_i, imm_i, use_imm_i, alu_op_i,
           instr_op_i, instr_ld_i, instr_st_i, instr_jm_i, instr_br_i, flush_i,
    input  stall_o, valid_o, pc_o, rd_o, alu_result_o, alu_zero_o, rs2_data_o,
           instr_op_o, instr_ld_o, instr_st_o, instr_jm_o, instr_br_o
  );

  modport slave (
    input  valid_i, pc_i, rd_i, rs1_data_i, rs2_data_i, imm_i, use_imm_i, alu_op_i,
           instr_op_i, instr_ld_i, instr_st_i, instr_jm_i, instr_br_i, flush_i,
    output stall_o, valid_o, pc_o, rd_o, alu_result_o, alu_zero_o, rs2_data_o,
           instr_op_o, instr_ld_o, instr_st_o, instr_jm_o, instr_br_o
  );
endinterface

// File: rtl/stage_ex.sv
// Execute stage: single-cycle ALU plus a one-bit-per-cycle shift-add multiplier
// that stalls decode while it runs; results are registered toward stage_mem.
module stage_ex #(
  parameter int WD_SIZE        = 32,
  parameter int INSTR_SIZE     = 32,
  parameter int INSTR_REG_BITS = 5
) (
  input logic       clk,
  input logic       reset,
  stage_ex_if.slave ex
);
  localparam int SHW = $clog2(WD_SIZE);
  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLL  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_SLT  = 4'd8;
  localparam logic [3:0] OP_SLTU = 4'd9;
  localparam logic [3:0] OP_MUL  = 4'd10;

  typedef enum logic {IDLE, BUSY} state_t;

  function automatic logic [WD_SIZE-1:0] alu_calc(input logic [3:0] op,
                                                  input logic [WD_SIZE-1:0] a,
                                                  input logic [WD_SIZE-1:0] b);
    logic signed [WD_SIZE-1:0] sa;
    logic signed [WD_SIZE-1:0] sb;
    logic [SHW-1:0]            sh;
    sa = a;
    sb = b;
    sh = b[SHW-1:0];
    case (op)
      OP_ADD:  alu_calc = a + b;
      OP_SUB:  alu_calc = a - b;
      OP_AND:  alu_calc = a & b;
      OP_OR:   alu_calc = a | b;
      OP_XOR:  alu_calc = a ^ b;
      OP_SLL:  alu_calc = a << sh;
      OP_SRL:  alu_calc = a >> sh;
      OP_SRA:  alu_calc = sa >>> sh;
      OP_SLT:  alu_calc = {{(WD_SIZE-1){1'b0}}, (sa < sb)};
      OP_SLTU: alu_calc = {{(WD_SIZE-1){1'b0}}, (a < b)};
      default: alu_calc = '0;
    endcase
  endfunction

  function automatic logic [WD_SIZE-1:0] mul_step(input logic [WD_SIZE-1:0] acc,
                                                  input logic [WD_SIZE-1:0] mcand,
                                                  input logic               mbit);
    mul_step = mbit ? acc + mcand : acc;
  endfunction

  state_t                    state, state_nxt;
  logic [SHW-1:0]            count;
  logic [WD_SIZE-1:0]        acc, mcand, mplier;
  logic [INSTR_SIZE-1:0]     mul_pc;
  logic [INSTR_REG_BITS-1:0] mul_rd;
  logic [WD_SIZE-1:0]        mul_rs2;
  logic [4:0]                mul_flags;

  logic                      mul_start, mul_last, iterate, load_alu, load_mul, stall;
  logic [WD_SIZE-1:0]        opb, alu_res, mul_res;
  logic [4:0]                flags_in;

  logic                      vld_p1;
  logic [INSTR_SIZE-1:0]     pc_p1;
  logic [INSTR_REG_BITS-1:0] rd_p1;
  logic [WD_SIZE-1:0]        res_p1;
  logic                      zero_p1;
  logic [WD_SIZE-1:0]        rs2_p1;
  logic [4:0]                flags_p1;

  assign opb      = ex.use_imm_i ? ex.imm_i : ex.rs2_data_i;
  assign flags_in = {ex.instr_op_i, ex.instr_ld_i, ex.instr_st_i, ex.instr_jm_i, ex.instr_br_i};
  assign alu_res  = ex.instr_jm_i ? WD_SIZE'(ex.pc_i + INSTR_SIZE'(4))
                                  : alu_calc(ex.alu_op_i, ex.rs1_data_i, opb);
  assign mul_res  = mul_flags[1] ? WD_SIZE'(mul_pc + INSTR_SIZE'(4))
                                 : mul_step(acc, mcand, mplier[0]);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (mul_start) state_nxt = BUSY;
      BUSY:    if (ex.flush_i || count == '0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mul_start = (state == IDLE) && ex.valid_i && (ex.alu_op_i == OP_MUL) && !ex.flush_i;
    mul_last  = (state == BUSY) && (count == '0);
    iterate   = (state == BUSY) && (count != '0) && !ex.flush_i;
    load_alu  = (state == IDLE) && ex.valid_i && (ex.alu_op_i != OP_MUL) && !ex.flush_i;
    load_mul  = mul_last && !ex.flush_i;
    stall     = mul_start || ((state == BUSY) && (count != '0));
  end

  assign ex.stall_o = stall;

  always_ff @(posedge clk) begin
    if (reset || ex.flush_i) count <= '0;
    else if (mul_start)      count <= SHW'(WD_SIZE - 1);
    else if (iterate)        count <= count - SHW'(1);
  end

  // Multiplier datapath: operands and the instruction's side-band held for the run
  always_ff @(posedge clk) begin
    if (mul_start) begin
      acc       <= '0;
      mcand     <= ex.rs1_data_i;
      mplier    <= opb;
      mul_pc    <= ex.pc_i;
      mul_rd    <= ex.rd_i;
      mul_rs2   <= ex.rs2_data_i;
      mul_flags <= flags_in;
    end else if (iterate) begin
      acc    <= mul_step(acc, mcand, mplier[0]);
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end
  end

  // p1: output register toward stage_mem; a bubble clears valid and flags only
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1   <= 1'b0;
      pc_p1    <= '0;
      rd_p1    <= '0;
      res_p1   <= '0;
      zero_p1  <= 1'b0;
      rs2_p1   <= '0;
      flags_p1 <= '0;
    end else if (load_alu) begin
      vld_p1   <= 1'b1;
      pc_p1    <= ex.pc_i;
      rd_p1    <= ex.rd_i;
      res_p1   <= alu_res;
      zero_p1  <= (alu_res == '0);
      rs2_p1   <= ex.rs2_data_i;
      flags_p1 <= flags_in;
    end else if (load_mul) begin
      vld_p1   <= 1'b1;
      pc_p1    <= mul_pc;
      rd_p1    <= mul_rd;
      res_p1   <= mul_res;
      zero_p1  <= (mul_res == '0);
      rs2_p1   <= mul_rs2;
      flags_p1 <= mul_flags;
    end else begin
      vld_p1   <= 1'b0;
      flags_p1 <= '0;
    end
  end

  assign ex.valid_o      = vld_p1;
  assign ex.pc_o         = pc_p1;
  assign ex.rd_o         = rd_p1;
  assign ex.alu_result_o = res_p1;
  assign ex.alu_zero_o   = zero_p1;
  assign ex.rs2_data_o   = rs2_p1;
  assign ex.instr_op_o   = flags_p1[4];
  assign ex.instr_ld_o   = flags_p1[3];
  assign ex.instr_st_o   = flags_p1[2];
  assign ex.instr_jm_o   = flags_p1[1];
  assign ex.instr_br_o   = flags_p1[0];
endmodule

// File: tb/tb_stage_ex.sv
// Scoreboard bench for stage_ex: expected results queued at issue, popped when
// valid_o appears; directed checks cover stall timing, flush and reset.
module tb_stage_ex;
  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [31:0] res;
    logic [31:0] rs2;
    logic [4:0]  flags;
  } exp_t;
  exp_t sb_q[$];

  stage_ex_if #(.WD_SIZE(32), .INSTR_SIZE(32), .INSTR_REG_BITS(5)) bus ();

  stage_ex #(.WD_SIZE(32), .INSTR_SIZE(32), .INSTR_REG_BITS(5)) dut (
    .clk   (clk),
    .reset (reset),
    .ex    (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic signed [31:0] s;
    case (op)
      4'd0:    model = a + b;
      4'd1:    model = a - b;
      4'd2:    model = a & b;
      4'd3:    model = a | b;
      4'd4:    model = a ^ b;
      4'd5:    model = a << b[4:0];
      4'd6:    model = a >> b[4:0];
      4'd7:    begin s = $signed(a) >>> b[4:0]; model = s; end
      4'd8:    model = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd9:    model = (a < b) ? 32'd1 : 32'd0;
      4'd10:   model = a * b;
      default: model = 32'd0;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] imm, input logic ui, input logic [4:0] flags,
                       input logic [31:0] pc, input logic [4:0] rd, input logic [31:0] exp_res,
                       input bit push);
    exp_t e;
    bus.valid_i    = 1'b1;
    bus.flush_i    = 1'b0;
    bus.alu_op_i   = op;
    bus.rs1_data_i = a;
    bus.rs2_data_i = b;
    bus.imm_i      = imm;
    bus.use_imm_i  = ui;
    bus.pc_i       = pc;
    bus.rd_i       = rd;
    {bus.instr_op_i, bus.instr_ld_i, bus.instr_st_i, bus.instr_jm_i, bus.instr_br_i} = flags;
    if (push) begin
      e.pc = pc; e.rd = rd; e.res = exp_res; e.rs2 = b; e.flags = flags;
      sb_q.push_back(e);
    end
  endtask

  task automatic mul_run(input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp_res,
                         input logic [31:0] pc, input logic [4:0] rd);
    drive(4'd10, a, b, 32'd0, 1'b0, 5'b10000, pc, rd, exp_res, 1'b1);
    for (int c = 0; c <= 32; c++) begin
      @(negedge clk);
      check($sformatf("mul_stall_c%0d", c), bus.stall_o, (c < 32) ? 1 : 0);
      if (c >= 1) check($sformatf("mul_bubble_c%0d", c), {bus.valid_o, bus.instr_op_o}, 0);
      step();
    end
  endtask

  // Scoreboard: every valid output must match the oldest queued expectation
  always @(negedge clk) begin
    exp_t e;
    if (!reset && bus.valid_o === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("unexpected_valid_qsize", sb_q.size(), 1);
      end else begin
        e = sb_q.pop_front();
        check("out_pc",    bus.pc_o, e.pc);
        check("out_rd",    bus.rd_o, e.rd);
        check("out_res",   bus.alu_result_o, e.res);
        check("out_zero",  bus.alu_zero_o, (e.res == 32'd0));
        check("out_rs2",   bus.rs2_data_o, e.rs2);
        check("out_flags", {bus.instr_op_o, bus.instr_ld_o, bus.instr_st_o,
                            bus.instr_jm_o, bus.instr_br_o}, e.flags);
      end
    end
  end

  initial begin
    logic [3:0]  op;
    logic [31:0] a, b, imm;
    logic        ui;

    reset = 1'b1;
    bus.valid_i = 1'b0; bus.flush_i = 1'b0; bus.alu_op_i = '0; bus.rs1_data_i = '0;
    bus.rs2_data_i = '0; bus.imm_i = '0; bus.use_imm_i = 1'b0; bus.pc_i = '0; bus.rd_i = '0;
    {bus.instr_op_i, bus.instr_ld_i, bus.instr_st_i, bus.instr_jm_i, bus.instr_br_i} = '0;
    step();
    step();
    @(negedge clk);
    check("rst_valid", bus.valid_o, 0);
    check("rst_result", bus.alu_result_o, 0);
    check("rst_pc_rd", {bus.pc_o, bus.rd_o}, 0);
    check("rst_stall", bus.stall_o, 0);
    step();
    reset = 1'b0;

    // directed single-cycle ops
    drive(4'd0, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1, 5'b10000, 32'h10, 5'd1, 32'd4, 1'b1); step();
    drive(4'd1, 32'h1234, 32'h1234, 32'd0, 1'b0, 5'b00001, 32'h14, 5'd2, 32'd0, 1'b1); step();
    drive(4'd7, 32'h8000_0000, 32'd4, 32'd0, 1'b0, 5'b10000, 32'h18, 5'd3, 32'hF800_0000, 1'b1); step();
    drive(4'd8, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 5'b10000, 32'h1C, 5'd4, 32'd1, 1'b1); step();
    drive(4'd9, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 5'b10000, 32'h20, 5'd5, 32'd0, 1'b1); step();
    drive(4'd0, 32'h55, 32'h66, 32'd0, 1'b0, 5'b00010, 32'h100, 5'd1, 32'h104, 1'b1); step();
    drive(4'd12, 32'd3, 32'd4, 32'd0, 1'b0, 5'b01000, 32'h108, 5'd6, 32'd0, 1'b1); step();
    bus.valid_i = 1'b0;
    step();
    @(negedge clk);
    check("bubble_valid_flags", {bus.valid_o, bus.instr_ld_o, bus.instr_op_o}, 0);
    check("bubble_pc_hold", bus.pc_o, 32'h108);
    step();

    // random back-to-back single-cycle ops
    for (int i = 0; i < 24; i++) begin
      op = 4'($urandom_range(0, 14));
      if (op >= 4'd10) op = op + 4'd1;
      a = $urandom; b = $urandom; imm = $urandom; ui = 1'($urandom_range(0, 1));
      if (i % 4 == 0) b = 32'd0;
      drive(op, a, b, imm, ui, 5'($urandom_range(0, 31)) & 5'b11101, 32'h200 + 32'(i * 4),
            5'($urandom), model(op, a, ui ? imm : b), 1'b1);
      step();
    end
    bus.valid_i = 1'b0;
    step();

    // multiplies, back-to-back
    mul_run(32'd7, 32'd6, 32'd42, 32'h300, 5'd7);
    mul_run(32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFD, 32'h304, 5'd8);
    a = $urandom; b = $urandom;
    mul_run(a, b, model(4'd10, a, b), 32'h308, 5'd9);
    bus.valid_i = 1'b0;
    @(negedge clk);
    check("mul_last_valid", bus.valid_o, 1);
    step();
    step();

    // flush at cycle 10 of a multiply
    drive(4'd10, 32'd9, 32'd9, 32'd0, 1'b0, 5'b10000, 32'h400, 5'd10, 32'd81, 1'b0);
    for (int c = 0; c < 10; c++) step();
    bus.flush_i = 1'b1;
    step();
    drive(4'd4, 32'hF0F0, 32'h0FF0, 32'd0, 1'b0, 5'b10000, 32'h404, 5'd11, 32'hFF00, 1'b1);
    @(negedge clk);
    check("flush_stall", bus.stall_o, 0);
    check("flush_bubble", bus.valid_o, 0);
    step();
    bus.valid_i = 1'b0;
    for (int c = 0; c < 40; c++) step();
    check("flush_qsize", sb_q.size(), 0);

    // reset at cycle 5 of a multiply
    drive(4'd10, 32'd11, 32'd13, 32'd0, 1'b0, 5'b10000, 32'h500, 5'd12, 32'd143, 1'b0);
    for (int c = 0; c < 5; c++) step();
    reset = 1'b1;
    bus.valid_i = 1'b0;
    step();
    reset = 1'b0;
    @(negedge clk);
    check("mrst_stall", bus.stall_o, 0);
    check("mrst_valid_result", {bus.valid_o, bus.alu_result_o}, 0);
    check("mrst_pc_rd_rs2", {bus.pc_o, bus.rd_o, bus.rs2_data_o[26:0]}, 0);
    check("mrst_flags", {bus.instr_op_o, bus.instr_ld_o, bus.instr_st_o,
                         bus.instr_jm_o, bus.instr_br_o, bus.alu_zero_o}, 0);
    step();
    drive(4'd5, 32'd1, 32'd31, 32'd0, 1'b0, 5'b10000, 32'h504, 5'd13, 32'h8000_0000, 1'b1);
    step();
    bus.valid_i = 1'b0;
    for (int c = 0; c < 40; c++) step();
    check("final_qsize", sb_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/stage_ex.md
# stage_ex

Execute stage of the five-stage pipeline, between decode and `stage_mem`. It computes single-cycle ALU results and a multi-cycle shift-add multiply, and registers the result, destination register, store data and instruction-class flags into `stage_mem`. It stalls decode for the whole multiply and drops its in-flight work when `flush_i` is asserted.

## Interface
Parameters:
- `WD_SIZE`, 32, data word width.
- `INSTR_SIZE`, 32, PC width.
- `INSTR_REG_BITS`, 5, register index width.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  one clock; reset is synchronous and active-high.
- `valid_i`  in  1  decode presents an instruction.
- `pc_i` / `pc_o`  in/out  INSTR_SIZE  instruction PC.
- `rd_i` / `rd_o`  in/out  INSTR_REG_BITS  destination register.
- `rs1_data_i`  in  WD_SIZE  operand A.
- `rs2_data_i`  in  WD_SIZE  operand B and store data.
- `imm_i`  in  WD_SIZE  sign-extended immediate.
- `use_imm_i`  in  1  when high, operand B = `imm_i`.
- `alu_op_i`  in  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU, 10 MUL; 11-15 give result 0.
- `instr_op_i`, `instr_ld_i`, `instr_st_i`, `instr_jm_i`, `instr_br_i`  in  1 each  class flags.
- `flush_i`  in  1  kill the current/in-flight instruction.
- `stall_o`  out  1  decode must hold all inputs stable.
- `valid_o`  out  1  output register holds a real instruction.
- `alu_result_o`  out  WD_SIZE  registered result.
- `alu_zero_o`  out  1  registered (result == 0).
- `rs2_data_o`  out  WD_SIZE  registered `rs2_data_i` (store data).
- `instr_op_o`, `instr_ld_o`, `instr_st_o`, `instr_jm_o`, `instr_br_o`  out  1 each  registered flags.

## Operation
- Operand B = `use_imm_i ? imm_i : rs2_data_i`.
- Shift amount = B[$clog2(WD_SIZE)-1:0]. SRA is arithmetic. SLT is signed and SLTU unsigned; both give 0 or 1.
- ADD and SUB wrap modulo 2^WD_SIZE.
- `instr_jm_i` high: the result is `pc_i + 4` (link value) regardless of `alu_op_i`.
- MUL returns the low WD_SIZE bits of A*B (identical for signed and unsigned). It uses a shift-add iteration, one bit per cycle:
  - if mplier[0], then acc += mcand;
  - mcand <<= 1; mplier >>= 1.
- FSM states: IDLE and BUSY.
  - IDLE, `valid_i & alu_op_i==MUL & !flush_i`: load acc=0, mcand=A, mplier=B, count=WD_SIZE-1; go to BUSY. No output is written this cycle (bubble).
  - BUSY, count != 0: iterate, count--, output bubble.
  - BUSY, count == 0: do the final iteration and write the product plus the held instruction's pc/rd/flags/rs2 to the outputs with `valid_o`=1. Go to IDLE. Inputs are ignored this cycle (decode is still presenting the MUL).
- Non-MUL with `valid_i` in IDLE: outputs load at the next edge.
- `valid_i`=0 in IDLE: outputs load a bubble.
- Bubble = `valid_o`=0 and all five `instr_*_o`=0. pc/rd/result/rs2 hold their previous values.
- `flush_i` has priority over everything:
  - the output loads a bubble;
  - the FSM goes to IDLE;
  - a MUL start in the same cycle is suppressed;
  - a flush in the final BUSY cycle discards the product.
- `reset` mid-multiply: the FSM goes to IDLE and the partial product is discarded.

## Timing
- Reset values: all outputs 0, `stall_o`=0, state IDLE, count 0.
- `stall_o` = (IDLE & `valid_i` & MUL & !`flush_i`) | (BUSY & count != 0). It is combinational.
- Single-cycle ops: latency 1. Inputs in cycle N appear on the outputs in cycle N+1; one instruction per cycle.
- MUL accepted in cycle N:
  - `stall_o` is high in cycles N..N+WD_SIZE-1;
  - `stall_o` is low in cycle N+WD_SIZE, and decode advances at that edge;
  - the product is valid on the outputs in cycle N+WD_SIZE+1.
  - Back-to-back MULs each cost WD_SIZE+1 cycles.
- No backpressure from `stage_mem`; the outputs update on every non-reset edge.

## Test plan
- ADD, A=5, B=imm 0xFFFFFFFF -> next cycle `alu_result_o`=4, `alu_zero_o`=0, `valid_o`=1.
- SUB with `instr_br_i`, A=B=0x1234 -> `alu_result_o`=0, `alu_zero_o`=1, `instr_br_o`=1.
- SRA, A=0x80000000, B=4 -> 0xF8000000. SLT, A=-1, B=1 -> 1. SLTU with the same operands -> 0.
- MUL 7*6 at cycle 0 -> `stall_o` high cycles 0-31, low in cycle 32, `alu_result_o`=42 with `valid_o`=1 in cycle 33, bubbles in cycles 1-32. MUL 0xFFFFFFFF*3 -> 0xFFFFFFFD.
- `flush_i` at cycle 10 of a MUL -> `stall_o` drops immediately, no product ever appears, and the next instruction in cycle 11 completes normally.
- `reset` at cycle 5 of a MUL -> all outputs 0 and `stall_o`=0 on the next cycle. JAL with `pc_i`=0x100 -> `alu_result_o`=0x104, `instr_jm_o`=1.
